// File: rtl/neuron_accumulator.sv
// One hidden neuron: saturating sum of N_INPUTS signed products, bias add,
// fixed-point rescale and clamped ReLU, presented on a valid/ready output.
module neuron_accumulator #(
    parameter int N_INPUTS   = 64,
    parameter int PROD_W     = 20,
    parameter int ACC_W      = 28,
    parameter int FRAC_SHIFT = 9,
    parameter int OUT_W      = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [PROD_W-1:0] mulVal,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         act_out,
    output logic                     busy
);
    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_BIAS, S_ACT, S_OUT
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  bias_q;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic [OUT_W-1:0]         act_next;
    logic                     xfer;
    logic                     out_hs;

    // One extra bit of headroom; disagreeing top bits mean the sum left the range.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    assign prod_ext   = {{(ACC_W-PROD_W){mulVal[PROD_W-1]}}, mulVal};
    assign prod_ready = (state_q == S_ACCUM);
    assign busy       = (state_q != S_IDLE);
    assign xfer       = prod_valid && prod_ready;
    assign out_hs     = out_valid && out_ready;
    assign shifted    = acc >>> FRAC_SHIFT;

    always_comb begin
        act_next = shifted[OUT_W-1:0];
        if (shifted[ACC_W-1])
            act_next = '0;
        else if (|shifted[ACC_W-2:OUT_W])
            act_next = '1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ACCUM;
            S_ACCUM: if (xfer && cnt == CNT_LAST) state_d = S_BIAS;
            S_BIAS:  state_d = S_ACT;
            S_ACT:   state_d = S_OUT;
            S_OUT:   if (out_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // out_valid rises one cycle after entering OUT, giving a 3-cycle tail latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            bias_q    <= '0;
            cnt       <= '0;
            act_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        cnt    <= '0;
                        bias_q <= bias;
                    end
                end
                S_ACCUM: begin
                    if (xfer) begin
                        acc <= sat_add(acc, prod_ext);
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BIAS: acc <= sat_add(acc, bias_q);
                S_ACT:  act_out <= act_next;
                S_OUT:  out_valid <= !out_hs;
                default: out_valid <= 1'b0;
            endcase
        end
    end
endmodule
